// File: rtl/branch_bht.sv
// Branch history table with target buffer: fetch-time direction/target
// prediction, execute-time training, mispredict redirect and statistics.
module branch_bht #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_ready,
  input  logic            i_lu_valid,
  input  logic [PC_W-1:0] i_lu_pc,
  output logic            o_pred_hit,
  output logic            o_pred_taken,
  output logic [PC_W-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target,
  input  logic            i_upd_pred_taken,
  input  logic [PC_W-1:0] i_upd_pred_target,
  output logic            o_mispredict,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic [31:0]     o_stat_lookups,
  output logic [31:0]     o_stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(1) << (CTR_W - 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];
  logic [CTR_W-1:0] r_ctr   [ENTRIES];

  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispred;

  logic [IDX_W-1:0] w_lu_idx;
  logic [TAG_W-1:0] w_lu_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic [PC_W-1:0]  w_lu_pc4;
  logic [PC_W-1:0]  w_up_pc4;
  logic             w_lu_hit;
  logic             w_lu_taken;
  logic             w_up_acc;
  logic             w_up_hit;
  logic             w_up_write;
  logic             w_mispred;
  logic [CTR_W-1:0] w_ctr_old;
  logic [CTR_W-1:0] w_ctr_nxt;
  logic             w_unused;

  assign w_unused = ^{i_lu_pc, i_upd_pc};

  assign w_lu_idx = i_lu_pc[IDX_W+1:2];
  assign w_lu_tag = i_lu_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_lu_pc4 = i_lu_pc + PC_W'(4);
  assign w_up_pc4 = i_upd_pc + PC_W'(4);

  assign o_ready = (r_state == S_RUN);

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (i_flush) begin
      w_state_nxt = S_INIT;
      w_ptr_nxt   = '0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          if (r_ptr == PTR_LAST) begin
            w_state_nxt = S_RUN;
          end else begin
            w_ptr_nxt = r_ptr + IDX_W'(1);
          end
        end
        S_RUN: begin
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_INIT;
          w_ptr_nxt   = '0;
        end
      endcase
    end
  end

  // Lookup: combinational, sees table contents before any same-cycle write
  assign w_lu_hit = o_ready & r_valid[w_lu_idx]
                  & (r_tag[w_lu_idx] == w_lu_tag);
  assign w_lu_taken = w_lu_hit & r_ctr[w_lu_idx][CTR_W-1];

  assign o_pred_hit    = w_lu_hit;
  assign o_pred_taken  = w_lu_taken;
  assign o_pred_target = w_lu_taken ? r_tgt[w_lu_idx] : w_lu_pc4;

  assign w_up_acc = i_upd_valid & o_ready & ~i_stall;
  assign w_up_hit = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
  assign w_up_write = w_up_acc & ~i_flush;

  assign w_mispred = w_up_acc
    & ((i_upd_taken != i_upd_pred_taken)
      | (i_upd_taken & (i_upd_target != i_upd_pred_target)));

  assign o_mispredict  = w_mispred;
  assign o_redirect_pc = i_upd_taken ? i_upd_target : w_up_pc4;

  assign w_ctr_old = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_old;
    if (i_upd_taken) begin
      if (w_ctr_old != '1) w_ctr_nxt = w_ctr_old + CTR_W'(1);
    end else begin
      if (w_ctr_old != '0) w_ctr_nxt = w_ctr_old - CTR_W'(1);
    end
  end

  // Table storage: INIT walk clears one entry per cycle, RUN trains
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        r_valid[r_ptr] <= 1'b0;
        r_ctr[r_ptr]   <= '0;
      end else if (w_up_write) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_ctr_nxt;
          if (i_upd_taken) r_tgt[w_up_idx] <= i_upd_target;
        end else if (i_upd_taken) begin
          r_valid[w_up_idx] <= 1'b1;
          r_tag[w_up_idx]   <= w_up_tag;
          r_tgt[w_up_idx]   <= i_upd_target;
          r_ctr[w_up_idx]   <= CTR_WT;
        end
      end
    end
  end

  // Saturating statistics, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (i_lu_valid && o_ready && !i_stall && r_stat_lookups != '1)
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_mispred && r_stat_mispred != '1)
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign o_stat_lookups = r_stat_lookups;
  assign o_stat_mispred = r_stat_mispred;

endmodule

// File: tb/tb_branch_bht.sv
// Scoreboard bench for branch_bht: driver queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_bht;
  localparam int PC_W    = 32;
  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ready, lu_valid;
  logic [31:0] lu_pc, pred_target, upd_pc, upd_target, upd_pred_target;
  logic [31:0] redirect_pc, stat_lk, stat_mp;
  logic        pred_hit, pred_taken, upd_valid, upd_taken, upd_pred_taken;
  logic        mispredict;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          c;
    string       name;
    int          sel;
    logic [31:0] v;
  } exp_t;
  exp_t q[$];

  branch_bht #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(2), .TAG_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .o_ready(ready), .i_lu_valid(lu_valid), .i_lu_pc(lu_pc),
    .o_pred_hit(pred_hit), .o_pred_taken(pred_taken),
    .o_pred_target(pred_target), .i_upd_valid(upd_valid),
    .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
    .i_upd_pred_target(upd_pred_target), .o_mispredict(mispredict),
    .o_redirect_pc(redirect_pc), .o_stat_lookups(stat_lk),
    .o_stat_mispred(stat_mp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int s);
    case (s)
      0: return {31'd0, pred_hit};
      1: return {31'd0, pred_taken};
      2: return pred_target;
      3: return {31'd0, mispredict};
      4: return redirect_pc;
      5: return {31'd0, ready};
      6: return stat_lk;
      default: return stat_mp;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin : pop
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = act(e.sel);
      n_chk++;
      if (e.c != cyc || a !== e.v)
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, a, e.v);
      else
        n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string n, input int s, input logic [31:0] v);
    q.push_back('{cyc, n, s, v});
  endtask

  task automatic want_lu(input string n, input logic h, input logic t,
                         input logic [31:0] tg);
    want({n, ".hit"}, 0, {31'd0, h});
    want({n, ".tkn"}, 1, {31'd0, t});
    want({n, ".tgt"}, 2, tg);
  endtask

  task automatic want_mp(input string n, input logic m,
                         input logic [31:0] r);
    want({n, ".mp"}, 3, {31'd0, m});
    if (m) want({n, ".redir"}, 4, r);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t,
                     input logic [31:0] tg, input logic pt,
                     input logic [31:0] ptg);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = t;
    upd_target = tg;
    upd_pred_taken = pt;
    upd_pred_target = ptg;
  endtask

  task automatic noupd();
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    lu_valid = 1'b0;
    lu_pc = '0;
    noupd();
    tick();
    tick();
    rst = 1'b0;

    // reset state, INIT walk ignores lookups and updates
    lu_valid = 1'b1;
    lu_pc = 32'h100;
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    want_lu("rst_lu", 1'b0, 1'b0, 32'h104);
    want_mp("rst", 1'b0, 32'h0);
    want("rst_rdy", 5, 32'd0);
    want("rst_lk", 6, 32'd0);
    want("rst_mpc", 7, 32'd0);
    for (int i = 1; i < ENTRIES; i++) begin
      tick();
      want("init_rdy", 5, 32'd0);
      want_mp("init", 1'b0, 32'h0);
    end

    // R: first RUN cycle, allocate 0x100 (read-before-write miss)
    tick();
    want("run_rdy", 5, 32'd1);
    want("run_lk", 6, 32'd0);
    want("run_mpc", 7, 32'd0);
    want_lu("pre_alloc", 1'b0, 1'b0, 32'h104);
    want_mp("alloc", 1'b1, 32'h200);

    tick();
    lu_valid = 1'b0;
    noupd();
    want_lu("post_alloc", 1'b1, 1'b1, 32'h200);
    want("lk1", 6, 32'd1);
    want("mpc1", 7, 32'd1);

    for (int i = 0; i < 4; i++) begin
      tick();
      upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      want_mp("sat_up", 1'b0, 32'h0);
    end

    tick();
    upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    want_mp("nt1", 1'b1, 32'h104);

    tick();
    want_lu("ctr2", 1'b1, 1'b1, 32'h200);
    want_mp("nt2", 1'b1, 32'h104);

    tick();
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    want_lu("ctr1", 1'b1, 1'b0, 32'h104);
    want_mp("nt3", 1'b0, 32'h0);
    want("mpc3", 7, 32'd3);

    tick();
    want_mp("nt4", 1'b0, 32'h0);

    tick();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    want_mp("tk_low", 1'b1, 32'h200);

    tick();
    upd(32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    want_lu("ctr_floor", 1'b1, 1'b0, 32'h104);
    want_mp("new_tgt", 1'b1, 32'h300);

    tick();
    upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    want_lu("tgt300", 1'b1, 1'b1, 32'h300);
    want_mp("bad_tgt", 1'b1, 32'h300);

    // alias at same index, different tag
    tick();
    upd(32'h100 + 4 * ENTRIES, 1'b1, 32'h400, 1'b0, 32'h204);
    want_lu("pre_alias", 1'b1, 1'b1, 32'h300);
    want_mp("alias", 1'b1, 32'h400);
    want("mpc6", 7, 32'd6);

    tick();
    noupd();
    want_lu("alias_old", 1'b0, 1'b0, 32'h104);

    tick();
    lu_pc = 32'h200;
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    want_lu("alias_new", 1'b1, 1'b1, 32'h400);
    want_mp("wrap", 1'b1, 32'h0);

    tick();
    noupd();
    lu_valid = 1'b1;
    lu_pc = 32'hFFFF_FFFC;
    want_lu("wrap_lu", 1'b0, 1'b0, 32'h0);
    want("mpc8", 7, 32'd8);

    // flush with a concurrent mispredicting update
    tick();
    lu_pc = 32'h200;
    flush = 1'b1;
    upd(32'h600, 1'b1, 32'h800, 1'b0, 32'h604);
    want_lu("flush_lu", 1'b1, 1'b1, 32'h400);
    want_mp("flush", 1'b1, 32'h800);

    tick();
    flush = 1'b0;
    upd(32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
    want("fl_rdy", 5, 32'd0);
    want("fl_lk", 6, 32'd3);
    want("fl_mpc", 7, 32'd9);
    want_lu("fl_init_lu", 1'b0, 1'b0, 32'h204);
    want_mp("fl_init", 1'b0, 32'h0);
    for (int i = 1; i < ENTRIES; i++) begin
      tick();
      want("fl_walk_rdy", 5, 32'd0);
      want_mp("fl_walk", 1'b0, 32'h0);
    end

    tick();
    lu_valid = 1'b0;
    noupd();
    want("fl_done_rdy", 5, 32'd1);
    want_lu("fl_miss200", 1'b0, 1'b0, 32'h204);
    want("fl_done_lk", 6, 32'd3);
    want("fl_done_mpc", 7, 32'd9);

    tick();
    lu_pc = 32'h600;
    want_lu("fl_miss600", 1'b0, 1'b0, 32'h604);

    tick();
    lu_pc = 32'h100;
    want_lu("fl_miss100", 1'b0, 1'b0, 32'h104);

    // stall with a held mispredicting update
    for (int i = 0; i < 3; i++) begin
      tick();
      stall = 1'b1;
      lu_valid = 1'b1;
      upd(32'h100, 1'b1, 32'h700, 1'b0, 32'h104);
      want_mp("stall", 1'b0, 32'h0);
      want_lu("stall_lu", 1'b0, 1'b0, 32'h104);
      want("stall_mpc", 7, 32'd9);
    end

    tick();
    stall = 1'b0;
    lu_valid = 1'b0;
    want_mp("unstall", 1'b1, 32'h700);
    want("unstall_mpc", 7, 32'd9);

    tick();
    noupd();
    want("post_stall_mpc", 7, 32'd10);
    want("post_stall_lk", 6, 32'd3);
    want_lu("post_stall_lu", 1'b1, 1'b1, 32'h700);

    // saturation of the mispredict counter
    tick();
    force dut.r_stat_mispred = 32'hFFFF_FFFF;
    want("sat_forced", 7, 32'hFFFF_FFFF);

    tick();
    release dut.r_stat_mispred;
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h700);
    want_mp("sat_mp", 1'b1, 32'h104);

    tick();
    noupd();
    want("sat_hold", 7, 32'hFFFF_FFFF);

    tick();
    want("sat_hold2", 7, 32'hFFFF_FFFF);

    tick();
    tick();
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
